svm_decision_unit: RTL

// - Downstream of the hw_svm feature pipeline. Consumes one kernel/dot-product beat per (test instance, SV) pair.
// - Weights each beat by a signed coefficient (alpha_i*y_i) and sums over NUM_SV beats.
// - Adds bias and emits one signed decision score plus class label per test instance, over a valid/ready handshake.

---
 rtl/svm_decision_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/svm_decision_unit.sv
// -----------------------------------------------------------------------------
// svm_decision_unit
//   Final stage of the SVM classifier. Each accepted beat carries the kernel
//   value for one (test instance, support vector) pair. The beat is multiplied
//   by that support vector's signed coefficient (alpha_i*y_i), the products of
//   NUM_SV consecutive beats are summed, and the bias is added. The result is
//   one signed decision score and one class label per test instance.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   in_valid     in_dot holds a beat this cycle
//   in_ready     beat accepted when in_valid && in_ready
//   in_dot       signed kernel / dot-product beat (ACCUM_SIZE)
//   coef_we      coefficient/bias table write strobe
//   coef_addr    0..NUM_SV-1 = coefficients, NUM_SV = bias; larger is ignored
//   coef_data    signed value written (DATA_SIZE)
//   out_valid    result register holds an unconsumed result
//   out_ready    consumer takes the result when out_valid && out_ready
//   out_score    signed sum(coef_i*k_i) + bias (SCORE_SIZE, wraps)
//   out_label    1 when out_score >= 0
//   out_idx      instance index of this result (wraps after NUM_INST-1)
//   out_last     out_idx == NUM_INST-1
//
// Configuration
//   POLY2_KERNEL_EN  when defined, a registered stage ahead of the multiplier
//                    forms k = (in_dot + 1)^2 truncated to ACCUM_SIZE bits.
//                    Otherwise k = in_dot.
//
// The coefficient table has no reset; it is loaded through the write port.
// -----------------------------------------------------------------------------
module svm_decision_unit #(
  parameter int DATA_SIZE  = 25,
  parameter int ACCUM_SIZE = 48,
  parameter int SCORE_SIZE = 80,
  parameter int NUM_SV     = 3,
  parameter int NUM_INST   = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [ACCUM_SIZE-1:0]                         in_dot,
  input  logic                                          coef_we,
  input  logic [$clog2(NUM_SV+1)-1:0]                   coef_addr,
  input  logic [DATA_SIZE-1:0]                          coef_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [SCORE_SIZE-1:0]                         out_score,
  output logic                                          out_label,
  output logic [((NUM_INST > 1) ? $clog2(NUM_INST) : 1)-1:0] out_idx,
  output logic                                          out_last
);

  localparam int ADDR_W = $clog2(NUM_SV + 1);
  localparam int SV_W   = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;
  localparam int IDX_W  = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;

  localparam logic [SV_W-1:0]   SV_LAST   = SV_W'(NUM_SV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_INST - 1);
  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(NUM_SV);

  logic [DATA_SIZE-1:0]  r_coef [NUM_SV+1];

  logic [SV_W-1:0]       r_sv_cnt;
  logic [SCORE_SIZE-1:0] r_acc;
  logic                  r_p_valid;
  logic                  r_p_last;
  logic [SCORE_SIZE-1:0] r_p_prod;
  logic                  r_out_valid;
  logic [SCORE_SIZE-1:0] r_out_score;
  logic                  r_out_label;
  logic [IDX_W-1:0]      r_out_idx;
  logic                  r_out_last;
  logic [IDX_W-1:0]      r_next_idx;

  logic                  w_advance;
  logic                  w_accept;
  logic [DATA_SIZE-1:0]  w_coef_sel;
  logic                  w_last_sel;
  logic                  w_pin_valid;
  logic [ACCUM_SIZE-1:0] w_pin_k;
  logic [DATA_SIZE-1:0]  w_pin_coef;
  logic                  w_pin_last;
  logic [SCORE_SIZE-1:0] w_k_ext;
  logic [SCORE_SIZE-1:0] w_c_ext;
  logic [SCORE_SIZE-1:0] w_prod;
  logic [SCORE_SIZE-1:0] w_bias_ext;
  logic [SCORE_SIZE-1:0] w_sum;
  logic [SCORE_SIZE-1:0] w_score;

  // A result waiting on the consumer freezes every stage, input included.
  assign w_advance = !(r_out_valid && !out_ready);
  assign w_accept  = in_valid && w_advance;
  assign in_ready  = w_advance;

  // The coefficient is selected at accept time, so a same-cycle table write
  // is only seen by later beats.
  assign w_coef_sel = r_coef[r_sv_cnt];
  assign w_last_sel = (r_sv_cnt == SV_LAST);

  always_ff @(posedge clk) begin
    if (coef_we && (coef_addr <= BIAS_ADDR)) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

`ifdef POLY2_KERNEL_EN
  logic                  r_k_valid;
  logic [ACCUM_SIZE-1:0] r_k_val;
  logic [DATA_SIZE-1:0]  r_k_coef;
  logic                  r_k_last;
  logic [ACCUM_SIZE-1:0] w_dot_p1;
  logic [ACCUM_SIZE-1:0] w_k_sq;

  // Low ACCUM_SIZE bits of the square depend only on the low bits of
  // (in_dot + 1), so wrapping the increment is harmless.
  assign w_dot_p1 = in_dot + ACCUM_SIZE'(1);
  assign w_k_sq   = w_dot_p1 * w_dot_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k_valid <= 1'b0;
      r_k_val   <= '0;
      r_k_coef  <= '0;
      r_k_last  <= 1'b0;
    end else if (w_advance) begin
      r_k_valid <= w_accept;
      if (w_accept) begin
        r_k_val  <= w_k_sq;
        r_k_coef <= w_coef_sel;
        r_k_last <= w_last_sel;
      end
    end
  end

  assign w_pin_valid = r_k_valid;
  assign w_pin_k     = r_k_val;
  assign w_pin_coef  = r_k_coef;
  assign w_pin_last  = r_k_last;
`else
  assign w_pin_valid = w_accept;
  assign w_pin_k     = in_dot;
  assign w_pin_coef  = w_coef_sel;
  assign w_pin_last  = w_last_sel;
`endif

  assign w_k_ext    = {{(SCORE_SIZE-ACCUM_SIZE){w_pin_k[ACCUM_SIZE-1]}}, w_pin_k};
  assign w_c_ext    = {{(SCORE_SIZE-DATA_SIZE){w_pin_coef[DATA_SIZE-1]}}, w_pin_coef};
  assign w_prod     = w_k_ext * w_c_ext;
  assign w_bias_ext = {{(SCORE_SIZE-DATA_SIZE){r_coef[NUM_SV][DATA_SIZE-1]}}, r_coef[NUM_SV]};
  assign w_sum      = r_acc + r_p_prod;
  assign w_score    = w_sum + w_bias_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sv_cnt    <= '0;
      r_acc       <= '0;
      r_p_valid   <= 1'b0;
      r_p_last    <= 1'b0;
      r_p_prod    <= '0;
      r_out_valid <= 1'b0;
      r_out_score <= '0;
      r_out_label <= 1'b0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_next_idx  <= '0;
    end else if (w_advance) begin
      if (w_accept) begin
        r_sv_cnt <= (r_sv_cnt == SV_LAST) ? '0 : r_sv_cnt + 1'b1;
      end
      r_p_valid <= w_pin_valid;
      if (w_pin_valid) begin
        r_p_prod <= w_prod;
        r_p_last <= w_pin_last;
      end
      // Advancing with out_valid high implies out_ready, so the old result is
      // consumed here; it is replaced only if a new one lands this edge.
      r_out_valid <= r_p_valid && r_p_last;
      if (r_p_valid) begin
        if (r_p_last) begin
          r_out_score <= w_score;
          r_out_label <= ~w_score[SCORE_SIZE-1];
          r_out_idx   <= r_next_idx;
          r_out_last  <= (r_next_idx == IDX_LAST);
          r_next_idx  <= (r_next_idx == IDX_LAST) ? '0 : r_next_idx + 1'b1;
          r_acc       <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_score = r_out_score;
  assign out_label = r_out_label;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule
